fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory's 10-bit byte read address combinationally.
- Captures the returned 32-bit big-endian instruction word into an IF/ID pipeline register for decode.
- Handles sequential increment, branch/jump redirect, stall, flush and halt.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 13 +
 rtl/if_id_reg.sv | 31 +++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
//   ADDR_W / DATA_W : PC byte-address width and instruction width
//   RESET_PC        : PC value loaded on reset
//   NOP_WORD        : word placed into IF/ID for a bubble
//   fetch_state_t   : fetch FSM states
//   ifid_t          : IF/ID pipeline register contents
package fetch_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 10'h000;
    localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc_plus4;
        logic              valid;
    } ifid_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch stage and the memory.
//   ReadAddress : byte address driven by the fetch stage (master)
//   Instruction : word returned combinationally by the memory (slave)
interface fetch_unit_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0] ReadAddress;
    logic [DATA_W-1:0] Instruction;

    modport master (output ReadAddress, input Instruction);
    modport slave  (input ReadAddress, output Instruction);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset, loads a bubble
//   load    : capture d
//   bubble  : load a bubble (takes priority over load)
//   d / q   : register input / contents
// With neither load nor bubble asserted the contents hold.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);

    localparam ifid_t BubbleVal = '{instr: NOP_WORD, pc_plus4: '0, valid: 1'b0};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= BubbleVal;
        end else if (bubble) begin
            q <= BubbleVal;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and captures the returned word into the IF/ID register.
//   Clk, ResetN     : clock, synchronous active-low reset
//   imem            : instruction-memory read bus (master side)
//   Stall, Flush    : hold the stage / replace IF/ID with a bubble
//   Redirect,Target : load PC from Target (low two bits masked)
//   Halt            : freeze fetch until reset
//   InstrOut, PcPlus4Out, ValidOut : IF/ID contents
//   Halted          : FSM is in HALTED
// Optional build macro FETCH_ALIGN_CHECK_EN adds MisalignedTrap: a redirect to a
// non-word-aligned Target pulses the trap for one cycle and leaves the PC alone.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic              Clk,
    input  logic              ResetN,
    fetch_unit_if.master      imem,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] Target,
    input  logic              Halt,
    output logic [DATA_W-1:0] InstrOut,
    output logic [ADDR_W-1:0] PcPlus4Out,
    output logic              ValidOut,
    output logic              Halted
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic              MisalignedTrap
`endif
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_target;
    fetch_state_t      state_q;
    logic              halted_q;
    logic              misaligned;
    logic              ifid_load;
    logic              ifid_bubble;
    ifid_t             ifid_d;
    ifid_t             ifid_q;

    // Wraps naturally at 2^ADDR_W.
    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign pc_target = Target & ~ADDR_W'(3);

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (Target[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign imem.ReadAddress = pc_q;

    assign ifid_d = '{instr: imem.Instruction, pc_plus4: pc_plus4, valid: 1'b1};

    // IF/ID control; redirect/halt discard the word fetched this cycle.
    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        unique case (state_q)
            RUN: begin
                if (Halt || Redirect) begin
                    ifid_bubble = 1'b1;
                end else if (Stall) begin
                    ifid_bubble = Flush;
                end else if (Flush) begin
                    ifid_bubble = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                end
            end
            default: ifid_bubble = 1'b1;
        endcase
    end

    // PC and FSM. Halt beats Redirect, Redirect beats Stall.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            pc_q     <= RESET_PC;
            state_q  <= BOOT;
            halted_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            MisalignedTrap <= 1'b0;
`endif
        end else begin
`ifdef FETCH_ALIGN_CHECK_EN
            MisalignedTrap <= 1'b0;
`endif
            unique case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (Halt) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (Redirect) begin
                        if (!misaligned) begin
                            pc_q <= pc_target;
                        end
`ifdef FETCH_ALIGN_CHECK_EN
                        MisalignedTrap <= misaligned;
`endif
                    end else if (!Stall) begin
                        pc_q <= pc_plus4;
                    end
                end
                HALTED: halted_q <= 1'b1;
                default: state_q <= BOOT;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (Clk),
        .reset_n (ResetN),
        .load    (ifid_load),
        .bubble  (ifid_bubble),
        .d       (ifid_d),
        .q       (ifid_q)
    );

    assign InstrOut   = ifid_q.instr;
    assign PcPlus4Out = ifid_q.pc_plus4;
    assign ValidOut   = ifid_q.valid;
    assign Halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a word-indexed instruction memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        Redirect = 1'b0;
    logic        Halt = 1'b0;
    logic [9:0]  Target = '0;
    logic [31:0] InstrOut;
    logic [9:0]  PcPlus4Out;
    logic        ValidOut;
    logic        Halted;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        MisalignedTrap;
`endif

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:255];

    always #5 Clk = ~Clk;

    fetch_unit_if bus ();

    assign bus.Instruction = mem[bus.ReadAddress[9:2]];

    fetch_unit dut (
        .Clk            (Clk),
        .ResetN         (ResetN),
        .imem           (bus),
        .Stall          (Stall),
        .Flush          (Flush),
        .Redirect       (Redirect),
        .Target         (Target),
        .Halt           (Halt),
        .InstrOut       (InstrOut),
        .PcPlus4Out     (PcPlus4Out),
        .ValidOut       (ValidOut),
        .Halted         (Halted)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .MisalignedTrap (MisalignedTrap)
`endif
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        step();
        step();
        total++; if (bus.ReadAddress !== 10'h000) begin bad++;
            $display("FAIL rst_ra: got %h want 000", bus.ReadAddress); end
        total++; if (ValidOut !== 1'b0) begin bad++;
            $display("FAIL rst_valid: got %b want 0", ValidOut); end
        total++; if (InstrOut !== 32'h0) begin bad++;
            $display("FAIL rst_instr: got %h want 0", InstrOut); end
        total++; if (PcPlus4Out !== 10'h000) begin bad++;
            $display("FAIL rst_pc4: got %h want 000", PcPlus4Out); end
        total++; if (Halted !== 1'b0) begin bad++;
            $display("FAIL rst_halted: got %b want 0", Halted); end
        ResetN = 1'b1;
    endtask

    task automatic test_run();
        step();  // BOOT
        total++; if (bus.ReadAddress !== 10'h000 || ValidOut !== 1'b0) begin bad++;
            $display("FAIL boot: ra=%h v=%b want 000/0", bus.ReadAddress, ValidOut); end
        step();
        total++; if (bus.ReadAddress !== 10'h004) begin bad++;
            $display("FAIL run_ra1: got %h want 004", bus.ReadAddress); end
        total++; if (InstrOut !== 32'h2008_0001 || ValidOut !== 1'b1 || PcPlus4Out !== 10'h004)
            begin bad++; $display("FAIL run_w0: got %h/%b/%h want 20080001/1/004",
                InstrOut, ValidOut, PcPlus4Out); end
        step();
        total++; if (bus.ReadAddress !== 10'h008) begin bad++;
            $display("FAIL run_ra2: got %h want 008", bus.ReadAddress); end
        total++; if (InstrOut !== 32'h2009_0002 || PcPlus4Out !== 10'h008) begin bad++;
            $display("FAIL run_w1: got %h/%h want 20090002/008", InstrOut, PcPlus4Out); end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (bus.ReadAddress !== 10'h008 || InstrOut !== 32'h2009_0002) begin bad++;
                $display("FAIL stall_hold%0d: got %h/%h want 008/20090002",
                    i, bus.ReadAddress, InstrOut); end
        end
        Stall = 1'b0;
        step();
        total++; if (bus.ReadAddress !== 10'h00C || InstrOut !== 32'hA000_0002 ||
                     PcPlus4Out !== 10'h00C) begin bad++;
            $display("FAIL stall_resume: got %h/%h/%h want 00c/a0000002/00c",
                bus.ReadAddress, InstrOut, PcPlus4Out); end
        step();
        total++; if (bus.ReadAddress !== 10'h010) begin bad++;
            $display("FAIL stall_next: got %h want 010", bus.ReadAddress); end
    endtask

    task automatic test_redirect();
        Redirect = 1'b1;
        Target   = 10'h100;
        step();
        total++; if (bus.ReadAddress !== 10'h100 || ValidOut !== 1'b0 || InstrOut !== 32'h0)
            begin bad++; $display("FAIL redir: got %h/%b/%h want 100/0/0",
                bus.ReadAddress, ValidOut, InstrOut); end
        Redirect = 1'b0;
        step();
        total++; if (InstrOut !== 32'hA000_0040 || ValidOut !== 1'b1 || PcPlus4Out !== 10'h104)
            begin bad++; $display("FAIL redir_word: got %h/%b/%h want a0000040/1/104",
                InstrOut, ValidOut, PcPlus4Out); end
        // Redirect must win over a simultaneous stall.
        Redirect = 1'b1;
        Stall    = 1'b1;
        Target   = 10'h200;
        step();
        total++; if (bus.ReadAddress !== 10'h200 || ValidOut !== 1'b0) begin bad++;
            $display("FAIL redir_stall: got %h/%b want 200/0", bus.ReadAddress, ValidOut); end
        Redirect = 1'b0;
        Stall    = 1'b0;
        step();
        total++; if (InstrOut !== 32'hA000_0080 || ValidOut !== 1'b1 ||
                     bus.ReadAddress !== 10'h204) begin bad++;
            $display("FAIL redir_stall_word: got %h/%b/%h want a0000080/1/204",
                InstrOut, ValidOut, bus.ReadAddress); end
    endtask

    task automatic test_flush();
        Flush = 1'b1;
        Stall = 1'b1;
        step();
        total++; if (bus.ReadAddress !== 10'h204 || ValidOut !== 1'b0) begin bad++;
            $display("FAIL flush_stall: got %h/%b want 204/0", bus.ReadAddress, ValidOut); end
        Stall = 1'b0;
        step();
        total++; if (bus.ReadAddress !== 10'h208 || ValidOut !== 1'b0) begin bad++;
            $display("FAIL flush_run: got %h/%b want 208/0", bus.ReadAddress, ValidOut); end
        Flush = 1'b0;
        step();
        total++; if (InstrOut !== 32'hA000_0082 || ValidOut !== 1'b1 ||
                     bus.ReadAddress !== 10'h20C) begin bad++;
            $display("FAIL flush_after: got %h/%b/%h want a0000082/1/20c",
                InstrOut, ValidOut, bus.ReadAddress); end
    endtask

    task automatic test_wrap();
        Redirect = 1'b1;
        Target   = 10'h3F8;
        step();
        Redirect = 1'b0;
        total++; if (bus.ReadAddress !== 10'h3F8) begin bad++;
            $display("FAIL wrap_redir: got %h want 3f8", bus.ReadAddress); end
        step();
        total++; if (bus.ReadAddress !== 10'h3FC || InstrOut !== 32'hA000_00FE ||
                     PcPlus4Out !== 10'h3FC) begin bad++;
            $display("FAIL wrap_3fc: got %h/%h/%h want 3fc/a00000fe/3fc",
                bus.ReadAddress, InstrOut, PcPlus4Out); end
        step();
        total++; if (bus.ReadAddress !== 10'h000 || InstrOut !== 32'hA000_00FF ||
                     PcPlus4Out !== 10'h000 || ValidOut !== 1'b1) begin bad++;
            $display("FAIL wrap_zero: got %h/%h/%h/%b want 000/a00000ff/000/1",
                bus.ReadAddress, InstrOut, PcPlus4Out, ValidOut); end
    endtask

    task automatic test_misalign();
        Redirect = 1'b1;
        Target   = 10'h102;
        step();
        Redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        total++; if (MisalignedTrap !== 1'b1 || bus.ReadAddress !== 10'h000) begin bad++;
            $display("FAIL mis_trap: got %b/%h want 1/000", MisalignedTrap, bus.ReadAddress); end
`else
        total++; if (bus.ReadAddress !== 10'h100) begin bad++;
            $display("FAIL mis_mask: got %h want 100", bus.ReadAddress); end
`endif
        total++; if (ValidOut !== 1'b0) begin bad++;
            $display("FAIL mis_bubble: got %b want 0", ValidOut); end
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        total++; if (MisalignedTrap !== 1'b0 || bus.ReadAddress !== 10'h004) begin bad++;
            $display("FAIL mis_pulse: got %b/%h want 0/004", MisalignedTrap, bus.ReadAddress); end
`else
        total++; if (bus.ReadAddress !== 10'h104) begin bad++;
            $display("FAIL mis_next: got %h want 104", bus.ReadAddress); end
`endif
    endtask

    task automatic test_halt();
        logic [9:0] frozen;
`ifdef FETCH_ALIGN_CHECK_EN
        frozen = 10'h004;
`else
        frozen = 10'h104;
`endif
        // Halt together with a redirect: halt wins, PC does not move.
        Halt     = 1'b1;
        Redirect = 1'b1;
        Target   = 10'h300;
        step();
        Halt     = 1'b0;
        Redirect = 1'b0;
        total++; if (Halted !== 1'b1 || ValidOut !== 1'b0 || bus.ReadAddress !== frozen)
            begin bad++; $display("FAIL halt_enter: got %b/%b/%h want 1/0/%h",
                Halted, ValidOut, bus.ReadAddress, frozen); end
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (Halted !== 1'b1 || ValidOut !== 1'b0 || bus.ReadAddress !== frozen)
                begin bad++; $display("FAIL halt_hold%0d: got %b/%b/%h want 1/0/%h",
                    i, Halted, ValidOut, bus.ReadAddress, frozen); end
        end
    endtask

    task automatic test_reset_exit();
        ResetN = 1'b0;
        step();
        ResetN = 1'b1;
        total++; if (bus.ReadAddress !== 10'h000 || Halted !== 1'b0 || ValidOut !== 1'b0)
            begin bad++; $display("FAIL rst_exit: got %h/%b/%b want 000/0/0",
                bus.ReadAddress, Halted, ValidOut); end
        step();
        total++; if (bus.ReadAddress !== 10'h000 || Halted !== 1'b0) begin bad++;
            $display("FAIL rst_boot: got %h/%b want 000/0", bus.ReadAddress, Halted); end
        step();
        total++; if (bus.ReadAddress !== 10'h004 || InstrOut !== 32'h2008_0001 ||
                     ValidOut !== 1'b1) begin bad++;
            $display("FAIL rst_restart: got %h/%h/%b want 004/20080001/1",
                bus.ReadAddress, InstrOut, ValidOut); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hA000_0000 | i;
        end
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;

        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_flush();
        test_wrap();
        test_misalign();
        test_halt();
        test_reset_exit();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
